// File: rtl/fir_decimator.sv
// Keeps every DECIM-th valid input sample (phase 0) and queues it in a small FIFO
// with ready/valid output, sticky overflow on dropped samples, and synchronous flush.
module fir_decimator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    flush,
    input  logic                    clr_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [$clog2(DEPTH):0]  fill,
    output logic                    overflow
);

    localparam int unsigned PhW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FillW = $clog2(DEPTH) + 1;

    logic [PhW-1:0]          r_phase;
    logic [PtrW-1:0]         r_wr_ptr;
    logic [PtrW-1:0]         r_rd_ptr;
    logic [FillW-1:0]        r_fill;
    logic                    r_overflow;
    logic signed [WIDTH-1:0] r_mem [DEPTH];

    logic [PhW-1:0]          w_phase_d;
    logic [PtrW-1:0]         w_wr_ptr_d;
    logic [PtrW-1:0]         w_rd_ptr_d;
    logic [FillW-1:0]        w_fill_d;
    logic                    w_overflow_d;

    logic w_keep;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Flush masks every push, pop and drop in its cycle.
    always_comb begin
        w_keep  = in_valid && (r_phase == '0);
        w_empty = (r_fill == '0);
        w_full  = (r_fill == FillW'(DEPTH));
        w_pop   = !flush && !w_empty && out_ready;
        w_push  = !flush && w_keep && (!w_full || w_pop);
        w_drop  = !flush && w_keep && w_full && !w_pop;
    end

    always_comb begin
        w_phase_d = r_phase;
        if (flush) begin
            w_phase_d = '0;
        end else if (in_valid) begin
            w_phase_d = (r_phase == PhW'(DECIM - 1)) ? '0 : r_phase + PhW'(1);
        end
    end

    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_fill_d   = r_fill;
        if (flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_fill_d   = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_d = r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   w_fill_d = r_fill + FillW'(1);
                2'b01:   w_fill_d = r_fill - FillW'(1);
                default: w_fill_d = r_fill;
            endcase
        end
    end

    // A new drop outranks a coincident clear.
    always_comb begin
        w_overflow_d = r_overflow;
        if (w_drop) begin
            w_overflow_d = 1'b1;
        end else if (clr_ovf) begin
            w_overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_phase    <= w_phase_d;
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_fill     <= w_fill_d;
            r_overflow <= w_overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Storage is never cleared, so the head is forced to zero while empty.
    always_comb begin
        out_valid = !w_empty;
        out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
        fill      = r_fill;
        overflow  = r_overflow;
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Scenario bench for fir_decimator (DECIM=4, DEPTH=4): expected kept samples go to a
// queue as stimulus is driven; a negedge monitor collects the samples actually popped.
module tb_fir_decimator;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               flush;
    logic               clr_ovf;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [2:0]         fill;
    logic               overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    fir_decimator #(
        .WIDTH(16),
        .DECIM(4),
        .DEPTH(4)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .fill     (fill),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs are stable at negedge, so this sees exactly the transfers of the coming edge.
    always @(negedge clk) begin
        if (reset && !flush && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic drive(input logic v, input int d, input logic rdy, input logic fl,
                         input logic co);
        in_valid  = v;
        in_data   = 16'(d);
        out_ready = rdy;
        flush     = fl;
        clr_ovf   = co;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    task automatic start();
        drive(1'b0, 0, 1'b0, 1'b1, 1'b1);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_tests++; if (fill !== 3'd0) begin n_fail++; $display("FAIL rst_fill: got %0d want 0", fill); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        n_tests++; if (out_data !== 16'd0) begin n_fail++; $display("FAIL rst_data: got %0d want 0", out_data); end
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [15:0] e, g;
        start();
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, i, 1'b1, 1'b0, 1'b0);
            if (i % 4 == 1) begin
                exp_q.push_back(16'(i));
                n_tests++; if (out_valid !== 1'b1 || out_data !== 16'(i)) begin n_fail++; $display("FAIL basic_latency: got v=%b d=%0d want v=1 d=%0d", out_valid, out_data, i); end
            end
            if (i % 4 == 2) begin
                n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped: got %b want 0", out_valid); end
            end
        end
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL basic_data: got %0d want %0d", $signed(g), $signed(e)); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] e, g;
        start();
        for (int i = 1; i <= 24; i++) begin
            drive(1'b1, i, 1'b0, 1'b0, 1'b0);
            if (i == 13) begin
                n_tests++; if (fill !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at13: got fill=%0d ovf=%b want fill=4 ovf=0", fill, overflow); end
            end
            if (i == 17) begin
                n_tests++; if (fill !== 3'd4 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_at17: got fill=%0d ovf=%b want fill=4 ovf=1", fill, overflow); end
            end
        end
        n_tests++; if (fill !== 3'd4 || out_data !== 16'd1 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got fill=%0d d=%0d ovf=%b want 4 1 1", fill, out_data, overflow); end
        exp_q.push_back(16'd1); exp_q.push_back(16'd5); exp_q.push_back(16'd9); exp_q.push_back(16'd13);
        for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (fill !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got fill=%0d v=%b want 0 0", fill, out_valid); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL ovf_data: got %0d want %0d", $signed(g), $signed(e)); end
        end
    endtask

    task automatic test_full_pop();
        logic [15:0] e, g;
        start();
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) exp_q.push_back(16'(10 * (i / 4 + 1)));
            drive(1'b1, (i % 4 == 0) ? 10 * (i / 4 + 1) : 1000 + i, 1'b0, 1'b0, 1'b0);
        end
        n_tests++; if (fill !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_pre: got fill=%0d ovf=%b want 4 0", fill, overflow); end
        exp_q.push_back(16'd100);
        drive(1'b1, 100, 1'b1, 1'b0, 1'b0);
        n_tests++; if (fill !== 3'd4 || overflow !== 1'b0 || out_data !== 16'd20) begin n_fail++; $display("FAIL fullpop_post: got fill=%0d ovf=%b d=%0d want 4 0 20", fill, overflow, out_data); end
        for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (fill !== 3'd0) begin n_fail++; $display("FAIL fullpop_drained: got %0d want 0", fill); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fullpop_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL fullpop_data: got %0d want %0d", $signed(g), $signed(e)); end
        end
    endtask

    task automatic test_gated();
        logic [15:0] e, g;
        int seq_d[9] = '{-3, 99, -2, 99, -1, 99, 0, 99, 1};
        start();
        exp_q.push_back(16'hFFFD); exp_q.push_back(16'd1);
        for (int i = 0; i < 9; i++) begin
            drive((i % 2) == 0, seq_d[i], 1'b1, 1'b0, 1'b0);
            if (i == 0) begin
                n_tests++; if (out_valid !== 1'b1 || out_data !== 16'hFFFD) begin n_fail++; $display("FAIL gated_first: got v=%b d=%0d want v=1 d=-3", out_valid, out_data); end
            end
            if (i == 1 || i == 4) begin
                n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gated_idle: got %b want 0", out_valid); end
            end
            if (i == 8) begin
                n_tests++; if (out_valid !== 1'b1 || out_data !== 16'd1) begin n_fail++; $display("FAIL gated_last: got v=%b d=%0d want v=1 d=1", out_valid, out_data); end
            end
        end
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL gated_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL gated_data: got %0d want %0d", $signed(g), $signed(e)); end
        end
    endtask

    task automatic test_flush();
        logic [15:0] e, g;
        start();
        drive(1'b1, 50, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) drive(1'b1, 50 + i, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 60, 1'b0, 1'b0, 1'b0);
        n_tests++; if (fill !== 3'd2) begin n_fail++; $display("FAIL flush_pre: got %0d want 2", fill); end
        drive(1'b1, 7, 1'b1, 1'b1, 1'b0);
        n_tests++; if (fill !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got fill=%0d v=%b want 0 0", fill, out_valid); end
        exp_q.push_back(16'd8);
        drive(1'b1, 8, 1'b1, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 16'd8) begin n_fail++; $display("FAIL flush_next: got v=%b d=%0d want v=1 d=8", out_valid, out_data); end
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL flush_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL flush_data: got %0d want %0d", $signed(g), $signed(e)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e, g;
        start();
        for (int i = 1; i <= 8; i++) drive(1'b1, i, 1'b0, 1'b0, 1'b0);
        n_tests++; if (fill !== 3'd2) begin n_fail++; $display("FAIL b2b_pre: got %0d want 2", fill); end
        exp_q.push_back(16'd1); exp_q.push_back(16'd5); exp_q.push_back(16'd9);
        drive(1'b1, 9, 1'b1, 1'b0, 1'b0);
        n_tests++; if (fill !== 3'd2 || out_data !== 16'd5) begin n_fail++; $display("FAIL b2b_post: got fill=%0d d=%0d want 2 5", fill, out_data); end
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (fill !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d want 0", fill); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL b2b_data: got %0d want %0d", $signed(g), $signed(e)); end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] e, g;
        start();
        // 21 samples leave the phase at 1, so a kept sample after release proves phase reset.
        for (int i = 0; i < 21; i++) drive(1'b1, 200 + i, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (fill !== 3'd3 || overflow !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got fill=%0d ovf=%b want 3 1", fill, overflow); end
        got_q.delete();
        exp_q.delete();
        #2;
        reset = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || fill !== 3'd0) begin n_fail++; $display("FAIL arst_fifo: got v=%b fill=%0d want 0 0", out_valid, fill); end
        n_tests++; if (overflow !== 1'b0 || out_data !== 16'd0) begin n_fail++; $display("FAIL arst_ovf: got ovf=%b d=%0d want 0 0", overflow, out_data); end
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(16'd77);
        drive(1'b1, 77, 1'b1, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 16'd77) begin n_fail++; $display("FAIL arst_first: got v=%b d=%0d want v=1 d=77", out_valid, out_data); end
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL arst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL arst_data: got %0d want %0d", $signed(g), $signed(e)); end
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_gated();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
